axi4_pcim_wr_arbiter: RTL and testbench

Two-slot AXI4 write-channel arbiter that shares the single 512-bit PCIM master port to the shell between the FSB write adapter (slot 0) and the AXIS trace adapter (slot 1). It replaces the vendor crossbar on the write path with a small RTL block. The block provides round-robin AW arbitration, in-order W steering, bounded outstanding writes and ID-based B routing. It sits between the two `m_axi4_*_adapter` instances and `cl_sh_pcim_bus`; read channels are not handled here.

---
 rtl/pcim_arb_pkg.sv | 38 +++
 rtl/bsg_fifo_1r1w_small.sv | 64 ++++++
 rtl/axi4_pcim_wr_arbiter.sv | 154 +++++++++++++++
 tb/tb_axi4_pcim_wr_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcim_arb_pkg.sv
// Shared types for the PCIM write-path arbiter.
// Holds the AW/W/B channel structs sized for the default 512-bit PCIM port
// (6-bit ID with the MSB reserved as the slot tag, 64-bit address), and the
// slot enum naming the two upstream adapters.
package pcim_arb_pkg;

    localparam int ID_W   = 6;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int STRB_W = DATA_W / 8;
    localparam int LEN_W  = 8;
    localparam int SIZE_W = 3;
    localparam int RESP_W = 2;

    typedef enum logic {
        SLOT_FSB  = 1'b0,
        SLOT_AXIS = 1'b1
    } slot_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
    } aw_chan_s;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_chan_s;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [RESP_W-1:0] resp;
    } b_chan_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO, one write and one read port.
// A pushed entry becomes visible on v_o/data_o the cycle after the push.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   v_i, ready_o, data_i    write side (ready_o = not full)
//   v_o, data_o, yumi_i     read side (yumi_i pops the head when v_o)
module bsg_fifo_1r1w_small #(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int CNT_W = $clog2(els_p + 1);

    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] mem_d [els_p];
    logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push, pop;

    assign ready_o = (cnt_q != CNT_W'(els_p));
    assign v_o     = (cnt_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q] = data_i;
            wptr_d = (wptr_q == PTR_W'(els_p - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_W'(els_p - 1)) ? '0 : rptr_q + 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/axi4_pcim_wr_arbiter.sv
// Two-slot AXI4 write arbiter sharing the 512-bit PCIM master port between
// the FSB write adapter (slot 0) and the AXIS trace adapter (slot 1).
// Ports:
//   clk_i, reset_i                       clock, synchronous active-high reset
//   s_aw_i/s_awvalid_i/s_awready_o       per-slot AW (round-robin granted)
//   s_w_i/s_wvalid_i/s_wready_o          per-slot W (steered by AW grant order)
//   s_b_o/s_bvalid_o/s_bready_i          B, routed by the ID slot tag
//   m_aw_*, m_w_*, m_b_*                 master side toward the shell
//   outstanding_o                        AWs granted without a B yet
module axi4_pcim_wr_arbiter
    import pcim_arb_pkg::*;
#(
    parameter int id_width_p        = ID_W,
    parameter int addr_width_p      = ADDR_W,
    parameter int data_width_p      = DATA_W,
    parameter int max_outstanding_p = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  aw_chan_s [1:0]                         s_aw_i,
    input  logic [1:0]                             s_awvalid_i,
    output logic [1:0]                             s_awready_o,
    input  w_chan_s [1:0]                          s_w_i,
    input  logic [1:0]                             s_wvalid_i,
    output logic [1:0]                             s_wready_o,
    output b_chan_s                                s_b_o,
    output logic [1:0]                             s_bvalid_o,
    input  logic [1:0]                             s_bready_i,
    output aw_chan_s                               m_aw_o,
    output logic                                   m_awvalid_o,
    input  logic                                   m_awready_i,
    output w_chan_s                                m_w_o,
    output logic                                   m_wvalid_o,
    input  logic                                   m_wready_i,
    input  b_chan_s                                m_b_i,
    input  logic                                   m_bvalid_i,
    output logic                                   m_bready_o,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o
);

    localparam int CNT_W = $clog2(max_outstanding_p + 1);

    logic             aw_vld_q, aw_vld_d;
    aw_chan_s         aw_q, aw_d;
    slot_e            ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic  eligible, grant;
    slot_e gnt_slot;
    logic  fifo_ready, fifo_v, fifo_head, w_pop;
    logic  b_slot, b_hs, b_dec;

    // ---------------- AW arbitration ----------------
    always_comb begin
        // The AW register may take a new grant in the same cycle it drains.
        eligible = ~reset_i & (~aw_vld_q | m_awready_i) & fifo_ready
                 & (cnt_q < CNT_W'(max_outstanding_p));
        gnt_slot = (&s_awvalid_i) ? ptr_q : slot_e'(s_awvalid_i[1]);
        grant    = eligible & (|s_awvalid_i);
        s_awready_o = '0;
        if (grant) s_awready_o[gnt_slot] = 1'b1;
    end

    always_comb begin
        aw_vld_d = aw_vld_q;
        aw_d     = aw_q;
        ptr_d    = ptr_q;
        if (aw_vld_q & m_awready_i) aw_vld_d = 1'b0;
        if (grant) begin
            aw_vld_d = 1'b1;
            aw_d     = s_aw_i[gnt_slot];
            // Tag the ID MSB with the slot so the B can find its way back.
            aw_d.id  = {gnt_slot, s_aw_i[gnt_slot].id[id_width_p-2:0]};
            ptr_d    = slot_e'(~gnt_slot);
        end
    end

    assign m_aw_o        = aw_q;
    assign m_awvalid_o   = aw_vld_q;
    assign outstanding_o = cnt_q;

    // ---------------- W steering ----------------
    bsg_fifo_1r1w_small #(
        .width_p (1),
        .els_p   (max_outstanding_p)
    ) u_worder (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (grant),
        .ready_o (fifo_ready),
        .data_i  (gnt_slot),
        .v_o     (fifo_v),
        .data_o  (fifo_head),
        .yumi_i  (w_pop)
    );

    always_comb begin
        m_w_o      = '0;
        m_wvalid_o = 1'b0;
        s_wready_o = '0;
        if (fifo_v) begin
            m_w_o                 = s_w_i[fifo_head];
            m_wvalid_o            = s_wvalid_i[fifo_head];
            s_wready_o[fifo_head] = m_wready_i;
        end
        w_pop = m_wvalid_o & m_wready_i & m_w_o.last;
    end

    // ---------------- B routing ----------------
    always_comb begin
        b_slot                   = m_b_i.id[id_width_p-1];
        s_b_o                    = m_b_i;
        s_b_o.id[id_width_p-1]   = 1'b0;
        s_bvalid_o               = '0;
        s_bvalid_o[b_slot]       = m_bvalid_i;
        m_bready_o               = s_bready_i[b_slot];
        b_hs                     = m_bvalid_i & m_bready_o;
        // A stray B at zero count is not allowed to underflow the counter.
        b_dec                    = b_hs & (cnt_q != '0);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (grant & ~b_dec)      cnt_d = cnt_q + 1'b1;
        else if (~grant & b_dec) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            aw_vld_q <= 1'b0;
            aw_q     <= '0;
            ptr_q    <= SLOT_FSB;
            cnt_q    <= '0;
        end else begin
            aw_vld_q <= aw_vld_d;
            aw_q     <= aw_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Simulation-only protocol checks.
    always @(posedge clk_i) begin
        if (reset_i) begin
            assert (id_width_p == ID_W && addr_width_p == ADDR_W && data_width_p == DATA_W);
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s_awvalid_i[i]) assert (!s_aw_i[i].id[id_width_p-1]);
            end
            assert (!(b_hs && cnt_q == '0));
        end
    end

endmodule

// File: tb/tb_axi4_pcim_wr_arbiter.sv
module tb_axi4_pcim_wr_arbiter;
    import pcim_arb_pkg::*;

    logic           clk_i = 1'b0;
    logic           reset_i;
    aw_chan_s [1:0] s_aw_i;
    logic [1:0]     s_awvalid_i, s_awready_o;
    w_chan_s [1:0]  s_w_i;
    logic [1:0]     s_wvalid_i, s_wready_o;
    b_chan_s        s_b_o;
    logic [1:0]     s_bvalid_o, s_bready_i;
    aw_chan_s       m_aw_o;
    logic           m_awvalid_o, m_awready_i;
    w_chan_s        m_w_o;
    logic           m_wvalid_o, m_wready_i;
    b_chan_s        m_b_i;
    logic           m_bvalid_i, m_bready_o;
    logic [2:0]     outstanding_o;

    axi4_pcim_wr_arbiter dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .s_aw_i(s_aw_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
        .s_w_i(s_w_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
        .s_b_o(s_b_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
        .m_aw_o(m_aw_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
        .m_w_o(m_w_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
        .m_b_i(m_b_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
        .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic [5:0] id; logic [63:0] addr; logic [7:0] len; } aw_exp_t;
    typedef struct { logic [31:0] d; logic last; } w_exp_t;
    typedef struct { logic [1:0] vld; logic [5:0] id; logic [1:0] resp; } b_exp_t;
    aw_exp_t aw_q[$];
    w_exp_t  w_q[$];
    b_exp_t  b_q[$];
    aw_exp_t ae;
    w_exp_t  we;
    b_exp_t  be;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: handshake not seen within cycle budget", name);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (m_awvalid_o && m_awready_i) begin
                if (aw_q.size() == 0) chk("aw_unexpected", aw_q.size(), 1);
                else begin
                    ae = aw_q.pop_front();
                    chk("aw_id", m_aw_o.id, ae.id);
                    chk("aw_addr", m_aw_o.addr, ae.addr);
                    chk("aw_len", m_aw_o.len, ae.len);
                end
            end
            if (m_wvalid_o && m_wready_i) begin
                if (w_q.size() == 0) chk("w_unexpected", w_q.size(), 1);
                else begin
                    we = w_q.pop_front();
                    chk("w_data", m_w_o.data[31:0], we.d);
                    chk("w_last", m_w_o.last, we.last);
                end
            end
            if (m_bvalid_i && m_bready_o) begin
                if (b_q.size() == 0) chk("b_unexpected", b_q.size(), 1);
                else begin
                    be = b_q.pop_front();
                    chk("b_slot_valid", s_bvalid_o, be.vld);
                    chk("b_id", s_b_o.id, be.id);
                    chk("b_resp", s_b_o.resp, be.resp);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_aw(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len);
        aw_q.push_back('{id, addr, len});
    endtask

    task automatic push_w(input logic [31:0] tag, input int n, input int blen);
        for (int b = 0; b < n; b++) w_q.push_back('{tag + 32'(b), (b == blen - 1)});
    endtask

    task automatic do_aw(input int s, input logic [5:0] id, input logic [63:0] addr,
                         input logic [7:0] len);
        int t;
        t = 0;
        s_aw_i[s].id   = id;
        s_aw_i[s].addr = addr;
        s_aw_i[s].len  = len;
        s_aw_i[s].size = 3'd6;
        s_awvalid_i[s] = 1'b1;
        @(negedge clk_i);
        while (!s_awready_o[s] && t < 200) begin @(negedge clk_i); t++; end
        if (t >= 200) timeout("aw_handshake");
        @(posedge clk_i);
        #1 s_awvalid_i[s] = 1'b0;
    endtask

    task automatic do_w(input int s, input int n, input int blen, input logic [31:0] tag);
        int t;
        for (int b = 0; b < n; b++) begin
            t = 0;
            s_w_i[s].data = '0;
            s_w_i[s].data[31:0] = tag + 32'(b);
            s_w_i[s].strb = '1;
            s_w_i[s].last = (b == blen - 1);
            s_wvalid_i[s] = 1'b1;
            @(negedge clk_i);
            while (!s_wready_o[s] && t < 200) begin @(negedge clk_i); t++; end
            if (t >= 200) timeout("w_handshake");
            @(posedge clk_i);
            #1;
        end
        s_wvalid_i[s] = 1'b0;
    endtask

    task automatic do_b(input logic [5:0] id, input logic [1:0] resp);
        int t;
        t = 0;
        b_q.push_back('{2'b01 << id[5], id & 6'h1f, resp});
        m_b_i.id   = id;
        m_b_i.resp = resp;
        m_bvalid_i = 1'b1;
        @(negedge clk_i);
        while (!m_bready_o && t < 200) begin @(negedge clk_i); t++; end
        if (t >= 200) timeout("b_handshake");
        @(posedge clk_i);
        #1 m_bvalid_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        s_awvalid_i = '0;
        s_wvalid_i  = '0;
        m_bvalid_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        s_aw_i = '0; s_awvalid_i = '0; s_w_i = '0; s_wvalid_i = '0;
        s_bready_i = 2'b11; m_awready_i = 1'b1; m_wready_i = 1'b1;
        m_b_i = '0; m_bvalid_i = 1'b0;
        do_reset();

        // Reset state
        @(negedge clk_i);
        chk("rst_m_awvalid", m_awvalid_o, 0);
        chk("rst_m_wvalid", m_wvalid_o, 0);
        chk("rst_s_awready", s_awready_o, 0);
        chk("rst_s_wready", s_wready_o, 0);
        chk("rst_s_bvalid", s_bvalid_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        @(posedge clk_i); #1;

        // Single-slot write: 4 beats, B id 0x05 back to slot 0
        push_aw(6'h05, 64'h1000, 8'd3);
        push_w(32'h100, 4, 4);
        fork
            begin do_aw(0, 6'h05, 64'h1000, 8'd3); chk("t1_outst_1", outstanding_o, 1); end
            do_w(0, 4, 4, 32'h100);
        join
        do_b(6'h05, 2'b00);
        chk("t1_outst_0", outstanding_o, 0);

        // Simultaneous requests from reset: grant order 0,1,0,1, slot 1 W valid first
        do_reset();
        push_aw(6'h01, 64'h100, 8'd1);
        push_aw(6'h22, 64'h200, 8'd1);
        push_aw(6'h03, 64'h300, 8'd1);
        push_aw(6'h24, 64'h400, 8'd1);
        push_w(32'h10, 2, 2); push_w(32'h20, 2, 2);
        push_w(32'h30, 2, 2); push_w(32'h40, 2, 2);
        fork
            begin do_aw(0, 6'h01, 64'h100, 8'd1); do_aw(0, 6'h03, 64'h300, 8'd1); end
            begin do_aw(1, 6'h02, 64'h200, 8'd1); do_aw(1, 6'h04, 64'h400, 8'd1); end
            begin do_w(1, 2, 2, 32'h20); do_w(1, 2, 2, 32'h40); end
            begin repeat (3) @(posedge clk_i); #1; do_w(0, 2, 2, 32'h10); do_w(0, 2, 2, 32'h30); end
        join
        chk("t2_outst_4", outstanding_o, 4);
        do_b(6'h22, 2'b10);
        do_b(6'h01, 2'b00);
        do_b(6'h24, 2'b01);
        do_b(6'h03, 2'b11);
        chk("t2_outst_0", outstanding_o, 0);

        // Outstanding limit: 5th AW waits for a B
        for (int i = 0; i < 5; i++) begin
            push_aw(6'h08 + 6'(i), 64'h5000 + 64'(i * 64), 8'd0);
            push_w(32'h50 + 32'(i), 1, 1);
        end
        fork
            for (int i = 0; i < 5; i++) do_w(0, 1, 1, 32'h50 + 32'(i));
            begin
                for (int i = 0; i < 4; i++) do_aw(0, 6'h08 + 6'(i), 64'h5000 + 64'(i * 64), 8'd0);
                chk("t3_outst_4", outstanding_o, 4);
                s_aw_i[0].id = 6'h0c; s_aw_i[0].addr = 64'h5100; s_aw_i[0].len = 8'd0;
                s_awvalid_i[0] = 1'b1;
                repeat (5) begin
                    @(negedge clk_i);
                    chk("t3_blocked", s_awready_o[0], 0);
                end
                chk("t3_saturated", outstanding_o, 4);
                @(posedge clk_i); #1;
                s_awvalid_i[0] = 1'b0;
                fork
                    do_b(6'h08, 2'b00);
                    do_aw(0, 6'h0c, 64'h5100, 8'd0);
                join
            end
        join
        do_b(6'h09, 2'b00); do_b(6'h0a, 2'b00); do_b(6'h0b, 2'b00); do_b(6'h0c, 2'b00);
        chk("t3_outst_0", outstanding_o, 0);

        // Grant and B handshake in the same cycle at count 2
        push_aw(6'h21, 64'h6000, 8'd0);
        push_aw(6'h22, 64'h6040, 8'd0);
        push_aw(6'h23, 64'h6080, 8'd0);
        push_w(32'h60, 1, 1); push_w(32'h61, 1, 1); push_w(32'h62, 1, 1);
        fork
            for (int i = 0; i < 3; i++) do_w(1, 1, 1, 32'h60 + 32'(i));
            begin
                do_aw(1, 6'h01, 64'h6000, 8'd0);
                do_aw(1, 6'h02, 64'h6040, 8'd0);
                chk("t4_outst_2", outstanding_o, 2);
                b_q.push_back('{2'b10, 6'h01, 2'b00});
                s_aw_i[1].id = 6'h03; s_aw_i[1].addr = 64'h6080; s_aw_i[1].len = 8'd0;
                s_awvalid_i[1] = 1'b1;
                m_b_i.id = 6'h21; m_b_i.resp = 2'b00; m_bvalid_i = 1'b1;
                @(negedge clk_i);
                chk("t4_awready", s_awready_o, 2'b10);
                chk("t4_bready", m_bready_o, 1);
                @(posedge clk_i); #1;
                s_awvalid_i[1] = 1'b0; m_bvalid_i = 1'b0;
                chk("t4_outst_same", outstanding_o, 2);
            end
        join
        do_b(6'h22, 2'b00); do_b(6'h23, 2'b00);
        chk("t4_outst_0", outstanding_o, 0);

        // AW backpressure for 10 cycles
        m_awready_i = 1'b0;
        push_aw(6'h26, 64'h7000, 8'd0);
        push_aw(6'h07, 64'h7100, 8'd0);
        push_w(32'h70, 1, 1); push_w(32'h71, 1, 1);
        do_aw(1, 6'h06, 64'h7000, 8'd0);
        s_aw_i[0].id = 6'h07; s_aw_i[0].addr = 64'h7100; s_aw_i[0].len = 8'd0;
        s_awvalid_i[0] = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            chk("t5_awvalid_held", m_awvalid_o, 1);
            chk("t5_aw_addr_held", m_aw_o.addr, 64'h7000);
            chk("t5_aw_id_held", m_aw_o.id, 6'h26);
            chk("t5_no_grant", s_awready_o, 0);
        end
        @(posedge clk_i); #1;
        s_awvalid_i[0] = 1'b0;
        m_awready_i = 1'b1;
        do_aw(0, 6'h07, 64'h7100, 8'd0);
        do_w(1, 1, 1, 32'h70);
        do_w(0, 1, 1, 32'h71);
        do_b(6'h26, 2'b00); do_b(6'h07, 2'b00);
        chk("t5_outst_0", outstanding_o, 0);

        // Reset after 2 of 8 beats, then a fresh write
        push_aw(6'h09, 64'h8000, 8'd7);
        push_w(32'h80, 2, 8);
        fork
            do_aw(0, 6'h09, 64'h8000, 8'd7);
            do_w(0, 2, 8, 32'h80);
        join
        chk("t6_outst_1", outstanding_o, 1);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        s_wvalid_i = 2'b11;
        s_w_i[0].last = 1'b1; s_w_i[1].last = 1'b1;
        @(negedge clk_i);
        chk("t6_m_awvalid", m_awvalid_o, 0);
        chk("t6_m_wvalid", m_wvalid_o, 0);
        chk("t6_s_wready", s_wready_o, 0);
        chk("t6_s_awready", s_awready_o, 0);
        chk("t6_outst_0", outstanding_o, 0);
        @(posedge clk_i); #1;
        s_wvalid_i = 2'b00;
        push_aw(6'h0a, 64'h9000, 8'd1);
        push_w(32'h90, 2, 2);
        fork
            do_aw(0, 6'h0a, 64'h9000, 8'd1);
            do_w(0, 2, 2, 32'h90);
        join
        do_b(6'h0a, 2'b01);
        chk("t6_new_outst_0", outstanding_o, 0);

        repeat (3) @(posedge clk_i);
        chk("aw_queue_drained", aw_q.size(), 0);
        chk("w_queue_drained", w_q.size(), 0);
        chk("b_queue_drained", b_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
